// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Multi-cycle load/store stage: effective-address generation, one
//            memory access per request, load byte/half extraction, and a
//            single-cycle response pulse. Optional macro LSU_ALIGN_CHECK_EN
//            enables misaligned-access faults.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_base,
  input  logic [ADDR_WIDTH-1:0] req_offset,
  input  logic [31:0]           req_store_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_fault,
  output logic                  mem_wren,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out
);

  localparam logic [1:0] c_LAST_WAIT = 2'(MEM_READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]            r_lane;
  logic [2:0]            r_funct3;
  logic                  r_is_store;
  logic [1:0]            r_cnt;
  logic [31:0]           r_resp_data;
  logic                  r_resp_fault;
  logic                  r_mem_wren;
  logic [2:0]            r_mem_funct3;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [31:0]           r_mem_data_in;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_ea;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_fault;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_data;

  assign req_ready   = (r_state == S_IDLE);
  assign w_accept    = req_valid && req_ready;
  assign w_ea        = req_base + req_offset;
  assign resp_valid  = (r_state == S_RESPOND);
  assign resp_data   = resp_valid ? r_resp_data : 32'd0;
  assign resp_fault  = resp_valid & r_resp_fault;
  assign mem_wren    = r_mem_wren;
  assign mem_funct3  = r_mem_funct3;
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;

  // Stores only have sb/sh/sw; loads additionally have lbu/lhu.
  always_comb begin
    w_illegal = 1'b0;
    if (req_is_store)
      w_illegal = (req_funct3 > 3'd2);
    else
      w_illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && w_ea[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_fault = w_illegal | w_misaligned;

  always_comb begin
    w_byte      = mem_data_out[{r_lane, 3'b000} +: 8];
    w_half      = mem_data_out[{r_lane[1], 4'b0000} +: 16];
    w_load_data = mem_data_out;
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd4:    w_load_data = {24'd0, w_byte};
      3'd5:    w_load_data = {16'd0, w_half};
      default: w_load_data = mem_data_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_fault ? S_RESPOND : S_ISSUE;
      S_ISSUE:   w_next = r_is_store ? S_RESPOND : S_WAIT;
      S_WAIT:    if (r_cnt == c_LAST_WAIT) w_next = S_RESPOND;
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Memory outputs are loaded at the accept edge so they are valid throughout ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane        <= 2'd0;
      r_funct3      <= 3'd0;
      r_is_store    <= 1'b0;
      r_cnt         <= 2'd0;
      r_resp_data   <= 32'd0;
      r_resp_fault  <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_mem_funct3  <= 3'd0;
      r_mem_address <= '0;
      r_mem_data_in <= 32'd0;
    end else begin
      r_mem_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lane       <= w_ea[1:0];
            r_funct3     <= req_funct3;
            r_is_store   <= req_is_store;
            r_resp_data  <= 32'd0;
            r_resp_fault <= w_fault;
            if (!w_fault) begin
              r_mem_wren <= req_is_store;
              if (req_is_store) begin
                r_mem_funct3  <= req_funct3;
                r_mem_address <= w_ea;
                r_mem_data_in <= req_store_data;
              end else begin
                r_mem_funct3  <= 3'b010;
                r_mem_address <= {w_ea[ADDR_WIDTH-1:2], 2'b00};
              end
            end
          end
        end
        S_ISSUE: r_cnt <= 2'd0;
        S_WAIT: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == c_LAST_WAIT)
            r_resp_data <= w_load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench driving two units (read latency 1 and 3) with the
//            same directed requests against a latency-accurate memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_store_data;

  logic [1:0]  req_ready_v;
  logic [1:0]  resp_valid_v;
  logic [1:0]  resp_fault_v;
  logic [1:0]  mem_wren_v;
  logic [31:0] resp_data_v    [2];
  logic [2:0]  mem_funct3_v   [2];
  logic [31:0] mem_address_v  [2];
  logic [31:0] mem_data_in_v  [2];
  logic [31:0] mem_data_out_v [2];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_READ_LATENCY(1), .ADDR_WIDTH(32)) u_dut_l1 (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready_v[0]),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_offset(req_offset), .req_store_data(req_store_data),
    .resp_valid(resp_valid_v[0]), .resp_data(resp_data_v[0]), .resp_fault(resp_fault_v[0]),
    .mem_wren(mem_wren_v[0]), .mem_funct3(mem_funct3_v[0]), .mem_address(mem_address_v[0]),
    .mem_data_in(mem_data_in_v[0]), .mem_data_out(mem_data_out_v[0])
  );

  load_store_unit #(.MEM_READ_LATENCY(3), .ADDR_WIDTH(32)) u_dut_l3 (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready_v[1]),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_offset(req_offset), .req_store_data(req_store_data),
    .resp_valid(resp_valid_v[1]), .resp_data(resp_data_v[1]), .resp_fault(resp_fault_v[1]),
    .mem_wren(mem_wren_v[1]), .mem_funct3(mem_funct3_v[1]), .mem_address(mem_address_v[1]),
    .mem_data_in(mem_data_in_v[1]), .mem_data_out(mem_data_out_v[1])
  );

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
    logic [7:0]  lat;
    logic        chk_mem;
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] mdata;
    logic [2:0]  mf3;
    logic [15:0] wren;
    logic [31:0] acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wren_cnt[2];
  int   n_stores = 0;
  exp_t mon_e;
  logic mon_got;

  // Word memory per unit; reads are a pipeline so data appears LAT edges after the address.
  logic [31:0] mem  [2][4096];
  logic [31:0] pipe [2][3];

  assign mem_data_out_v[0] = pipe[0][0];
  assign mem_data_out_v[1] = pipe[1][2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] w;
    w = old;
    case (f3[1:0])
      2'b00:   w[{a, 3'b000} +: 8] = d[7:0];
      2'b01:   w[{a[1], 4'b0000} +: 16] = d[15:0];
      default: w = d;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (mem_wren_v[i])
        mem[i][mem_address_v[i][13:2]] <= merge(mem[i][mem_address_v[i][13:2]], mem_data_in_v[i],
                                                mem_funct3_v[i], mem_address_v[i][1:0]);
      pipe[i][0] <= mem[i][mem_address_v[i][13:2]];
      for (int k = 1; k < 3; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end

  // Monitor: pops the scoreboard whenever a unit presents a response.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_wren_v[i]) wren_cnt[i]++;
      if (resp_valid_v[i]) begin
        mon_got = 1'b0;
        if (i == 0 && q0.size() > 0) begin mon_e = q0.pop_front(); mon_got = 1'b1; end
        else if (i == 1 && q1.size() > 0) begin mon_e = q1.pop_front(); mon_got = 1'b1; end
        if (!mon_got) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected 0", i);
        end else begin
          chk($sformatf("resp_data dut%0d", i), resp_data_v[i], mon_e.data);
          chk($sformatf("resp_fault dut%0d", i), {31'd0, resp_fault_v[i]}, {31'd0, mon_e.fault});
          chk($sformatf("latency dut%0d", i), cyc - mon_e.acc + 1, {24'd0, mon_e.lat});
          chk($sformatf("wren_count dut%0d", i), wren_cnt[i], {16'd0, mon_e.wren});
          if (mon_e.chk_mem) begin
            chk($sformatf("mem_address dut%0d", i), mem_address_v[i], mon_e.addr);
            chk($sformatf("mem_funct3 dut%0d", i), {29'd0, mem_funct3_v[i]}, {29'd0, mon_e.mf3});
            if (mon_e.is_store)
              chk($sformatf("mem_data_in dut%0d", i), mem_data_in_v[i], mon_e.mdata);
          end
        end
      end else begin
        chk($sformatf("idle_resp dut%0d", i), {resp_data_v[i][31:1], resp_data_v[i][0] | resp_fault_v[i]}, 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(req_ready_v[0] && req_ready_v[1]) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=%b expected 11", req_ready_v);
    end
  endtask

  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] base,
                      input logic [31:0] off, input logic [31:0] sdata,
                      input logic [31:0] exp_data, input logic exp_fault);
    exp_t e;
    logic [31:0] ea;
    wait_ready();
    req_is_store = st; req_funct3 = f3; req_base = base; req_offset = off;
    req_store_data = sdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ea = base + off;
    if (st && !exp_fault) n_stores++;
    e.data     = exp_data;
    e.fault    = exp_fault;
    e.chk_mem  = !exp_fault;
    e.is_store = st;
    e.addr     = st ? ea : {ea[31:2], 2'b00};
    e.mdata    = sdata;
    e.mf3      = st ? f3 : 3'b010;
    e.wren     = 16'(n_stores);
    e.acc      = cyc;
    for (int i = 0; i < 2; i++) begin
      e.lat = exp_fault ? 8'd1 : (st ? 8'd2 : 8'(2 + lat_of(i)));
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s req_ready dut%0d", tag, i), {31'd0, req_ready_v[i]}, 32'd1);
      chk($sformatf("%s resp_valid dut%0d", tag, i), {31'd0, resp_valid_v[i]}, 32'd0);
      chk($sformatf("%s mem_wren dut%0d", tag, i), {31'd0, mem_wren_v[i]}, 32'd0);
      chk($sformatf("%s mem_address dut%0d", tag, i), mem_address_v[i], 32'd0);
      chk($sformatf("%s mem_funct3 dut%0d", tag, i), {29'd0, mem_funct3_v[i]}, 32'd0);
      chk($sformatf("%s mem_data_in dut%0d", tag, i), mem_data_in_v[i], 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      wren_cnt[i] = 0;
      for (int k = 0; k < 4096; k++) mem[i][k] = 32'd0;
      mem[i][12'h800] = 32'h11223344;
      mem[i][12'h801] = 32'h80FF7F01;
    end
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_base = 32'd0; req_offset = 32'd0; req_store_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Loads from word 0x80FF7F01 at 0x2004
    send(1'b0, 3'd0, 32'h2000, 32'd7, 32'd0, 32'hFFFFFF80, 1'b0);
    send(1'b0, 3'd4, 32'h2000, 32'd7, 32'd0, 32'h00000080, 1'b0);
    send(1'b0, 3'd1, 32'h2000, 32'd6, 32'd0, 32'hFFFF80FF, 1'b0);
    send(1'b0, 3'd5, 32'h2000, 32'd6, 32'd0, 32'h000080FF, 1'b0);
    send(1'b0, 3'd2, 32'h2000, 32'd4, 32'd0, 32'h80FF7F01, 1'b0);
    send(1'b0, 3'd0, 32'h2000, 32'd4, 32'd0, 32'h00000001, 1'b0);
    send(1'b0, 3'd0, 32'h2000, 32'd5, 32'd0, 32'h0000007F, 1'b0);
    send(1'b0, 3'd1, 32'h2000, 32'd4, 32'd0, 32'h00007F01, 1'b0);

    // Stores with read-back
    send(1'b1, 3'd2, 32'h2000, 32'd4, 32'hDEADBEEF, 32'd0, 1'b0);
    send(1'b0, 3'd2, 32'h2000, 32'd4, 32'd0, 32'hDEADBEEF, 1'b0);
    send(1'b1, 3'd0, 32'h2000, 32'd5, 32'h12345678, 32'd0, 1'b0);
    send(1'b0, 3'd2, 32'h2008, 32'hFFFFFFFC, 32'd0, 32'hDEAD78EF, 1'b0);

    // Illegal funct3
    send(1'b0, 3'd3, 32'h2000, 32'd4, 32'd0, 32'd0, 1'b1);
    send(1'b0, 3'd6, 32'h2000, 32'd4, 32'd0, 32'd0, 1'b1);
    send(1'b0, 3'd7, 32'h2000, 32'd4, 32'd0, 32'd0, 1'b1);
    send(1'b1, 3'd4, 32'h2000, 32'd4, 32'hFFFFFFFF, 32'd0, 1'b1);
    send(1'b1, 3'd3, 32'h2000, 32'd4, 32'hFFFFFFFF, 32'd0, 1'b1);

    // Address wrap
    send(1'b1, 3'd2, 32'hFFFFFFFC, 32'd8, 32'hCAFEF00D, 32'd0, 1'b0);
    send(1'b0, 3'd2, 32'h00000000, 32'd4, 32'd0, 32'hCAFEF00D, 1'b0);

    // Misaligned accesses
`ifdef LSU_ALIGN_CHECK_EN
    send(1'b0, 3'd2, 32'h2000, 32'd2, 32'd0, 32'd0, 1'b1);
    send(1'b0, 3'd1, 32'h2000, 32'd5, 32'd0, 32'd0, 1'b1);
    send(1'b1, 3'd1, 32'h3000, 32'd1, 32'h0000ABCD, 32'd0, 1'b1);
`else
    send(1'b0, 3'd2, 32'h2000, 32'd2, 32'd0, 32'h11223344, 1'b0);
    send(1'b0, 3'd1, 32'h2000, 32'd5, 32'd0, 32'h000078EF, 1'b0);
    send(1'b1, 3'd1, 32'h3000, 32'd1, 32'h0000ABCD, 32'd0, 1'b0);
`endif

    // Reset while both units are in WAIT: the load must vanish without a response
    wait_ready();
    req_is_store = 1'b0; req_funct3 = 3'd2; req_base = 32'h2000; req_offset = 32'd4;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("post_reset req_ready dut%0d", i), {31'd0, req_ready_v[i]}, 32'd1);
    send(1'b0, 3'd2, 32'h2000, 32'd4, 32'd0, 32'hDEAD78EF, 1'b0);

    for (int n = 0; n < 50 && (q0.size() > 0 || q1.size() > 0); n++) @(posedge clk);
    #1;
    chk("drain", q0.size() + q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle load/store stage between the core's execute state and the data-memory port of the memory module. It accepts one load or store request per handshake and computes the effective address. For loads it reads the aligned word and extracts, sign-extends or zero-extends the byte or half. It returns a single-cycle response pulse that the core's write-back state consumes into the register file.

Parameters:
MEM_READ_LATENCY, 1, clock cycles from address presented (sampled at clk edge) to mem_data_out valid; legal range 1-4.
ADDR_WIDTH, 32, effective-address width; arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  core presents a memory request.
req_ready  out  1  unit idle, can accept a request.
req_is_store  in  1  1 = sb/sh/sw, 0 = lb/lh/lw/lbu/lhu.
req_funct3  in  3  RV32I funct3 of the instruction.
req_base  in  32  rs1 value.
req_offset  in  32  sign-extended imm_i (load) or imm_s (store).
req_store_data  in  32  rs2 value.
resp_valid  out  1  one-cycle pulse: response fields valid.
resp_data  out  32  extended load result; 0 for stores and faults.
resp_fault  out  1  request rejected (illegal funct3 or misaligned); no memory access performed.
mem_wren  out  1  to memory dmem_wren.
mem_funct3  out  3  to memory funct3.
mem_address  out  32  to memory dmem_address.
mem_data_in  out  32  to memory dmem_data_in.
mem_data_out  in  32  from memory dmem_data_out.

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0; req_ready=1; resp_valid=0, resp_data=0, resp_fault=0, mem_wren=0, mem_funct3=0, mem_address=0, mem_data_in=0. Requests are ignored while reset is high. A transaction in flight is dropped without a response. mem_wren falls immediately.
- Handshake: accept on rising clk when req_valid && req_ready. req_ready = (state==IDLE). No response backpressure: the core must sample resp_valid in its single high cycle.
- At acceptance, register ea = req_base + req_offset (32-bit, wrap, carry discarded), funct3, is_store and store data.
- Legality: loads accept funct3 0,1,2,4,5; stores accept 0,1,2. Any other funct3 -> fault.
- Alignment: half (funct3[1:0]=01) needs ea[0]=0. Word (10) needs ea[1:0]=00. Byte is always aligned.
- States:
  - IDLE -> ISSUE on accept, or -> RESPOND with resp_fault=1 if the request is illegal or misaligned.
  - ISSUE (1 cycle): drive mem outputs. Store: mem_wren=1, mem_funct3=funct3, mem_address=ea, mem_data_in=store data -> RESPOND. Load: mem_wren=0, mem_funct3=3'b010, mem_address={ea[31:2],2'b00} -> WAIT, counter=0.
  - WAIT: hold mem outputs; increment counter. On the cycle the counter reaches MEM_READ_LATENCY-1, capture mem_data_out -> RESPOND.
  - RESPOND (1 cycle): resp_valid=1 with resp_data/resp_fault -> IDLE. mem_wren=0.
- mem_wren is high only in ISSUE of a store: exactly one cycle per store, never for faults.
- Load extraction uses lane = ea[1:0]. lb/lbu take byte lane*8. lh/lhu take half ea[1]*16. Sign-extend for funct3 0,1; zero-extend for 4,5. lw is passed through unchanged.
- Latency from accept edge to resp_valid high: store 2 cycles; load 2+MEM_READ_LATENCY; fault 1.
- Outputs outside RESPOND: resp_valid=0, resp_data=0, resp_fault=0. Mem outputs hold their last values except mem_wren.
- Back-to-back: req_ready returns in the cycle after RESPOND. A request held valid across RESPOND is accepted at the next edge.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined: the alignment check above is active. Misaligned requests fault and skip memory.
- Undefined: no alignment check. Only illegal funct3 faults.
  - Misaligned stores go to memory with the raw ea.
  - Misaligned halves use ea[1] for lane select, ignoring ea[0].
  - Misaligned words read the word at {ea[31:2],00}.

Test Plan:
- Store: base=0x2000, off=4, funct3=010, data=0xDEADBEEF -> mem_wren=1 for exactly 1 cycle with address 0x2004, data 0xDEADBEEF. resp_valid 2 cycles after accept, resp_fault=0.
- Load byte signed: memory word @0x2004=0x80FF7F01, base=0x2000, off=7, lb -> mem_address=0x2004, mem_funct3=010, resp_data=0xFFFFFF80 at 3 cycles (latency 1). Repeat with lbu -> 0x00000080.
- Load half: same word, off=6, lh -> 0xFFFF80FF; lhu -> 0x000080FF. lw off=4 -> 0x80FF7F01.
- Faults: lw at ea=0x2002 with LSU_ALIGN_CHECK_EN -> resp_fault=1, resp_data=0, no mem_wren, 1-cycle latency. Load funct3=3 -> fault. Store funct3=4 -> fault.
- Wrap: base=0xFFFFFFFC, off=8, sw -> mem_address=0x00000004.
- Async reset asserted during WAIT with MEM_READ_LATENCY=3 -> no resp_valid, req_ready=1 after release. The next request completes normally.
